// File: rtl/sdf_pkg.sv
// Shared helpers for the multi-flux SDF blocks: reset polarity,
// tag-width computation and per-flux slicing of packed buses.
package sdf_pkg;

    // Reset is asserted when rst equals this value.
    localparam logic RST_ACTIVE = 1'b0;

    // Bits needed to encode n distinct tags, never less than one.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

    // Low bit of flux f inside a packed bus of w-bit slices.
    function automatic int flux_lo(input int f, input int w);
        return f * w;
    endfunction

endpackage

// File: rtl/sdf_flux_fifo.sv
// Single-flux FIFO with first-word-fall-through head.
// A write and a read in the same cycle move both pointers and keep the
// count. There is no bypass when empty, so rdata never depends
// combinationally on wdata.
module sdf_flux_fifo
    import sdf_pkg::*;
#(
    parameter int PW    = 7,
    parameter int DEPTH = 4
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          wr,
    input  logic [PW-1:0] wdata,
    input  logic          rd,
    output logic [PW-1:0] rdata,
    output logic          empty,
    output logic          full
);

    localparam int AW = clog2_min1(DEPTH);
    localparam int CW = clog2_min1(DEPTH + 1);

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic wr_ok;
    logic rd_ok;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A read of an empty FIFO is ignored. The top already blocks writes
    // while any flux is full; the local guard keeps this block safe on
    // its own.
    assign wr_ok = wr && !full;
    assign rd_ok = rd && !empty;

    assign rdata = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge ck) begin
        if (rst == RST_ACTIVE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage. It is left unreset because its contents are
    // don't-care while the FIFO is empty.
    always_ff @(posedge ck) begin
        if (rst != RST_ACTIVE && wr_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sdf_tag_demux.sv
// Tag demultiplexer: splits a tagged {tag, payload} stream into FLUX
// independent FIFOs, each exposed as an empty/read reader interface.
module sdf_tag_demux
    import sdf_pkg::*;
#(
    parameter  int FLUX      = 2,
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 4,
    localparam int TAG_WIDTH = clog2_min1(FLUX),
    localparam int PW        = WIDTH - TAG_WIDTH
) (
    input  logic               ck,
    input  logic               rst,
    input  logic               in0_wr,
    input  logic [WIDTH-1:0]   in0_data,
    output logic               in0_full,
    output logic [PW*FLUX-1:0] out_data,
    output logic [FLUX-1:0]    out_empty,
    input  logic [FLUX-1:0]    out_read,
    output logic               err_ovf,
    output logic               err_tag
);

    logic [TAG_WIDTH-1:0] tag;
    logic [PW-1:0]        payload;
    logic                 tag_ok;
    logic                 accept;
    logic [FLUX-1:0]      wr_vec;
    logic [FLUX-1:0]      full_vec;

    assign tag     = in0_data[WIDTH-1 -: TAG_WIDTH];
    assign payload = in0_data[PW-1:0];
    assign tag_ok  = (int'(tag) < FLUX);

    // The producer cannot see the tag in advance, so any full flux stalls
    // the whole stream. This is built from registered state only.
    assign in0_full = |full_vec;
    assign accept   = in0_wr && !in0_full && tag_ok;

    // Steer an accepted word to the flux named by its tag.
    always_comb begin
        wr_vec = '0;
        for (int f = 0; f < FLUX; f++)
            wr_vec[f] = accept && (int'(tag) == f);
    end

    for (genvar f = 0; f < FLUX; f++) begin : g_flux
        sdf_flux_fifo #(
            .PW    (PW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .ck    (ck),
            .rst   (rst),
            .wr    (wr_vec[f]),
            .wdata (payload),
            .rd    (out_read[f]),
            .rdata (out_data[flux_lo(f, PW) +: PW]),
            .empty (out_empty[f]),
            .full  (full_vec[f])
        );
    end

    // Sticky error flags. Only reset clears them.
    always_ff @(posedge ck) begin
        if (rst == RST_ACTIVE) begin
            err_ovf <= 1'b0;
            err_tag <= 1'b0;
        end else begin
            if (in0_wr && in0_full) err_ovf <= 1'b1;
            if (in0_wr && !tag_ok)  err_tag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdf_tag_demux.sv
// Directed bench for sdf_tag_demux with FLUX=2, WIDTH=8, DEPTH=4 (PW=7).
module tb_sdf_tag_demux;

    logic        ck = 1'b0;
    logic        rst;
    logic        in0_wr;
    logic [7:0]  in0_data;
    logic        in0_full;
    logic [13:0] out_data;
    logic [1:0]  out_empty;
    logic [1:0]  out_read;
    logic        err_ovf;
    logic        err_tag;

    int errors = 0;
    int checks = 0;

    always #5 ck = ~ck;

    sdf_tag_demux #(.FLUX(2), .WIDTH(8), .DEPTH(4)) dut (
        .ck        (ck),
        .rst       (rst),
        .in0_wr    (in0_wr),
        .in0_data  (in0_data),
        .in0_full  (in0_full),
        .out_data  (out_data),
        .out_empty (out_empty),
        .out_read  (out_read),
        .err_ovf   (err_ovf),
        .err_tag   (err_tag)
    );

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] data;
        logic [1:0] rd;
        logic [1:0] e_empty;
        logic       e_full;
        logic       e_ovf;
        logic       e_tag;
        logic [1:0] chk;   // which flux heads to compare
        logic [6:0] e_d0;
        logic [6:0] e_d1;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic r, logic w, logic [7:0] d, logic [1:0] rd,
                                logic [1:0] emp, logic fu, logic ov,
                                logic [1:0] chk, logic [6:0] d0, logic [6:0] d1);
        vec_t v;
        v.rst = r; v.wr = w; v.data = d; v.rd = rd;
        v.e_empty = emp; v.e_full = fu; v.e_ovf = ov; v.e_tag = 1'b0;
        v.chk = chk; v.e_d0 = d0; v.e_d1 = d1;
        vecs.push_back(v);
    endfunction

    task automatic cmp(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(logic r, logic w, logic [7:0] d, logic [1:0] rd);
        rst = r; in0_wr = w; in0_data = d; out_read = rd;
        @(posedge ck);
        #1;
        rst = 1'b1; in0_wr = 1'b0; in0_data = 8'h00; out_read = 2'b00;
    endtask

    initial begin
        rst = 1'b0; in0_wr = 1'b0; in0_data = 8'h00; out_read = 2'b00;

        //   rst wr  data   rd     empty  full ovf chk    d0     d1
        // reset held for two cycles
        add(0, 0, 8'h00, 2'b00, 2'b11, 0, 0, 2'b00, 7'h00, 7'h00);
        add(0, 0, 8'h00, 2'b00, 2'b11, 0, 0, 2'b00, 7'h00, 7'h00);
        // tag routing
        add(1, 1, 8'h85, 2'b00, 2'b01, 0, 0, 2'b10, 7'h00, 7'h05);
        add(1, 0, 8'h00, 2'b10, 2'b11, 0, 0, 2'b00, 7'h00, 7'h00);
        // fill flux0 and overflow
        add(1, 1, 8'h01, 2'b00, 2'b10, 0, 0, 2'b01, 7'h01, 7'h00);
        add(1, 1, 8'h02, 2'b00, 2'b10, 0, 0, 2'b01, 7'h01, 7'h00);
        add(1, 1, 8'h03, 2'b00, 2'b10, 0, 0, 2'b01, 7'h01, 7'h00);
        add(1, 1, 8'h04, 2'b00, 2'b10, 1, 0, 2'b01, 7'h01, 7'h00);
        add(1, 1, 8'h07, 2'b00, 2'b10, 1, 1, 2'b01, 7'h01, 7'h00);
        add(1, 0, 8'h00, 2'b01, 2'b10, 0, 1, 2'b01, 7'h02, 7'h00);
        add(1, 0, 8'h00, 2'b01, 2'b10, 0, 1, 2'b01, 7'h03, 7'h00);
        add(1, 0, 8'h00, 2'b01, 2'b10, 0, 1, 2'b01, 7'h04, 7'h00);
        add(1, 0, 8'h00, 2'b01, 2'b11, 0, 1, 2'b00, 7'h00, 7'h00);
        // concurrent write+read on flux0, read of empty flux1
        add(1, 1, 8'h0A, 2'b00, 2'b10, 0, 1, 2'b01, 7'h0A, 7'h00);
        add(1, 1, 8'h0B, 2'b00, 2'b10, 0, 1, 2'b01, 7'h0A, 7'h00);
        add(1, 1, 8'h0C, 2'b11, 2'b10, 0, 1, 2'b01, 7'h0B, 7'h00);
        add(1, 0, 8'h00, 2'b01, 2'b10, 0, 1, 2'b01, 7'h0C, 7'h00);
        add(1, 0, 8'h00, 2'b01, 2'b11, 0, 1, 2'b00, 7'h00, 7'h00);
        // reset mid-operation with a write in the same cycle
        add(1, 1, 8'h11, 2'b00, 2'b10, 0, 1, 2'b01, 7'h11, 7'h00);
        add(1, 1, 8'h85, 2'b00, 2'b00, 0, 1, 2'b11, 7'h11, 7'h05);
        add(0, 1, 8'h22, 2'b00, 2'b11, 0, 0, 2'b00, 7'h00, 7'h00);
        add(1, 0, 8'h00, 2'b00, 2'b11, 0, 0, 2'b00, 7'h00, 7'h00);
        // write+read on an empty flux: only the write lands
        add(1, 1, 8'h8F, 2'b10, 2'b01, 0, 0, 2'b10, 7'h00, 7'h0F);
        add(1, 0, 8'h00, 2'b10, 2'b11, 0, 0, 2'b00, 7'h00, 7'h00);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].data, vecs[i].rd);
            cmp($sformatf("v%0d out_empty", i), int'(out_empty), int'(vecs[i].e_empty));
            cmp($sformatf("v%0d in0_full", i),  int'(in0_full),  int'(vecs[i].e_full));
            cmp($sformatf("v%0d err_ovf", i),   int'(err_ovf),   int'(vecs[i].e_ovf));
            cmp($sformatf("v%0d err_tag", i),   int'(err_tag),   int'(vecs[i].e_tag));
            if (vecs[i].chk[0])
                cmp($sformatf("v%0d head0", i), int'(out_data[6:0]),  int'(vecs[i].e_d0));
            if (vecs[i].chk[1])
                cmp($sformatf("v%0d head1", i), int'(out_data[13:7]), int'(vecs[i].e_d1));
        end

        // Wrap-around on flux1: pointers cycle through DEPTH more than twice.
        for (int k = 1; k <= 10; k++) begin
            logic [7:0] w;
            w = 8'h80 | 8'(k);
            step(1'b1, 1'b1, w, 2'b00);
            cmp($sformatf("wrap%0d empty1", k), int'(out_empty[1]), 0);
            cmp($sformatf("wrap%0d head1", k),  int'(out_data[13:7]), k);
            step(1'b1, 1'b0, 8'h00, 2'b10);
            cmp($sformatf("wrap%0d drained", k), int'(out_empty), 3);
        end
        cmp("wrap err_ovf", int'(err_ovf), 0);
        cmp("wrap in0_full", int'(in0_full), 0);
        cmp("wrap err_tag", int'(err_tag), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, expected finish before 100000");
        $fatal(1);
    end

endmodule
